// File: rtl/taiga_types.sv
// taiga_types: shared CLINT address map, offset type and byte-lane merge helper
package taiga_types;
    typedef logic [15:0] clint_addr_t;
    localparam clint_addr_t CLINT_MSIP_BASE = 16'h0000;
    localparam clint_addr_t CLINT_MTIMECMP_BASE = 16'h4000;
    localparam clint_addr_t CLINT_MTIME_BASE = 16'hBFF8;
    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/clint_timer_unit_if.sv
// clint_timer_unit_if: single-cycle peripheral bus port of the CLINT
interface clint_timer_unit_if;
    import taiga_types::*;
    logic req;
    logic wr;
    clint_addr_t addr;
    logic [31:0] wdata;
    logic [3:0] be;
    logic ack;
    logic [31:0] rdata;
    modport master (output req, wr, addr, wdata, be, input ack, rdata);
    modport slave (input req, wr, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/clint_mtimecmp_reg.sv
// clint_mtimecmp_reg: one hart's 64-bit mtimecmp with byte-enable writes and registered mtip
module clint_mtimecmp_reg import taiga_types::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  logic [63:0] mtime,
    output logic [63:0] cmp,
    output logic        irq
);
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp <= '1;
            irq <= 1'b0;
        end else begin
            if (we_lo) cmp[31:0] <= merge_be(cmp[31:0], wdata, be);
            if (we_hi) cmp[63:32] <= merge_be(cmp[63:32], wdata, be);
            irq <= mtime >= cmp;
        end
    end
endmodule

// File: rtl/clint_timer_unit.sv
// clint_timer_unit: core-local interruptor with mtime, per-hart mtimecmp/msip and a 1-cycle bus port
module clint_timer_unit import taiga_types::*; #(
    parameter int          NUM_HARTS     = 2,
    parameter int          TICK_DIV      = 1,
    parameter clint_addr_t BASE_MSIP     = CLINT_MSIP_BASE,
    parameter clint_addr_t BASE_MTIMECMP = CLINT_MTIMECMP_BASE,
    parameter clint_addr_t BASE_MTIME    = CLINT_MTIME_BASE
) (
    input  logic                 clk,
    input  logic                 rst,
    clint_timer_unit_if.slave    bus,
    output logic [NUM_HARTS-1:0] timer_interrupt,
    output logic [NUM_HARTS-1:0] sw_interrupt
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [PW-1:0] prescaler;
    logic tick;
    logic [63:0] mtime;
    logic [NUM_HARTS-1:0] msip;
    logic [63:0] cmp_val [NUM_HARTS];
    logic [NUM_HARTS-1:0] cmp_we_lo, cmp_we_hi;
    logic [13:0] wa, msip_w, cmp_w, mt_w;
    logic msip_hit, cmp_hit, mt_hit, wr_en, mt_we_lo, mt_we_hi, rd_msip;
    logic [63:0] rd_cmp;
    logic [31:0] rd_val, mt_lo_nxt, mt_hi_nxt;
    // word-granular offsets into each region; addresses below a base wrap high and miss
    assign wa = bus.addr[15:2];
    assign msip_w = wa - BASE_MSIP[15:2];
    assign cmp_w = wa - BASE_MTIMECMP[15:2];
    assign mt_w = wa - BASE_MTIME[15:2];
    assign msip_hit = msip_w < 14'(NUM_HARTS);
    assign cmp_hit = cmp_w[13:1] < 13'(NUM_HARTS);
    assign mt_hit = cmp_w == cmp_w && mt_w[13:1] == '0;
    assign wr_en = bus.req & bus.wr;
    assign mt_we_lo = wr_en & mt_hit & ~mt_w[0];
    assign mt_we_hi = wr_en & mt_hit & mt_w[0];
    assign tick = prescaler == PW'(TICK_DIV - 1);
    always_comb begin
        rd_msip = 1'b0;
        rd_cmp = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (msip_w[2:0] == 3'(h)) rd_msip = msip[h];
            if (cmp_w[3:1] == 3'(h)) rd_cmp = cmp_val[h];
        end
    end
    assign rd_val = mt_hit ? (mt_w[0] ? mtime[63:32] : mtime[31:0]) :
                    cmp_hit ? (cmp_w[0] ? rd_cmp[63:32] : rd_cmp[31:0]) :
                    msip_hit ? {31'b0, rd_msip} : '0;
    // a write to either mtime word suppresses the low-to-high carry of that tick
    assign mt_lo_nxt = mt_we_lo ? merge_be(mtime[31:0], bus.wdata, bus.be) : mtime[31:0] + 32'(tick);
    assign mt_hi_nxt = mt_we_hi ? merge_be(mtime[63:32], bus.wdata, bus.be) :
                       mtime[63:32] + 32'(tick & (&mtime[31:0]) & ~mt_we_lo);
    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_cmp
        assign cmp_we_lo[h] = wr_en & cmp_hit & (cmp_w[3:1] == 3'(h)) & ~cmp_w[0];
        assign cmp_we_hi[h] = wr_en & cmp_hit & (cmp_w[3:1] == 3'(h)) & cmp_w[0];
        clint_mtimecmp_reg u_cmp (
            .clk(clk), .rst(rst), .we_lo(cmp_we_lo[h]), .we_hi(cmp_we_hi[h]),
            .wdata(bus.wdata), .be(bus.be), .mtime(mtime),
            .cmp(cmp_val[h]), .irq(timer_interrupt[h])
        );
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            mtime <= '0;
            msip <= '0;
            sw_interrupt <= '0;
            bus.ack <= 1'b0;
            bus.rdata <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            mtime <= {mt_hi_nxt, mt_lo_nxt};
            sw_interrupt <= msip;
            bus.ack <= bus.req;
            bus.rdata <= (bus.req & ~bus.wr) ? rd_val : '0;
            for (int h = 0; h < NUM_HARTS; h++)
                if (wr_en && msip_hit && msip_w[2:0] == 3'(h) && bus.be[0]) msip[h] <= bus.wdata[0];
        end
    end
endmodule

// File: doc/clint_timer_unit.md
Name: clint_timer_unit

Overview:
Core-local interruptor that sits directly upstream of gc_unit and drives its timer_interrupt and interrupt inputs.
- Holds a 64-bit free-running mtime, one 64-bit mtimecmp per hart, and one msip bit per hart.
- Exposes these registers through a single-cycle memory-mapped slave port on the peripheral bus.
- Produces registered per-hart timer and software interrupt levels for the dual-core system.

Parameters:
NUM_HARTS, 2, number of harts served (1..8)
TICK_DIV, 1, clk cycles per mtime increment (1 = every cycle; >=1)
BASE_MSIP, 16'h0000, offset of msip[0]; msip[h] at BASE_MSIP+4h
BASE_MTIMECMP, 16'h4000, offset of mtimecmp[0] low word; hart h at +8h (low), +8h+4 (high)
BASE_MTIME, 16'hBFF8, offset of mtime low word; high word at +4

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req  in  1  bus request, one-cycle pulse per access
wr  in  1  1 = write, 0 = read; sampled with req
addr  in  16  byte offset, word aligned; addr[1:0] ignored
wdata  in  32  write data
be  in  4  byte enables for writes
ack  out  1  access complete, exactly one cycle after req
rdata  out  32  read data, valid while ack=1, else 0
timer_interrupt  out  NUM_HARTS  per-hart mtip level to gc_unit
sw_interrupt  out  NUM_HARTS  per-hart msip level to gc_unit interrupt input

Behaviour:
- Reset values:
  - mtime = 0; prescaler = 0.
  - every mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - msip = 0; ack = 0; rdata = 0; timer_interrupt = 0; sw_interrupt = 0.
- Reset mid-access: a req in the reset cycle is dropped; no ack is produced.
- Prescaler: counter 0..TICK_DIV-1.
  - tick = (prescaler == TICK_DIV-1); the prescaler wraps to 0 on tick.
  - TICK_DIV=1 gives tick every cycle.
- mtime: increments by 1 on tick. The low-word carry propagates to the high word in the same cycle. 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Bus timing:
  - req in cycle N gives ack=1 in cycle N+1; rdata is valid in N+1.
  - A new req may be issued in cycle N+1, so throughput is 1 access per cycle.
  - No backpressure; ack is never stalled.
- Writes:
  - Applied at the clock edge ending cycle N; visible to reads issued in N+1.
  - Byte lanes are honoured by be.
  - msip uses only bit 0; other bits are read as 0 and writes to them are ignored.
- Write vs tick collision: a write to either mtime word in the same cycle as a tick overrides the increment for the written word only.
  - A write to the high word in a tick cycle keeps the incremented low word and drops that tick's carry.
  - A write to the low word in a tick cycle keeps the high word unincremented.
- Reads:
  - Return the register value at the start of cycle N, i.e. before any same-cycle write.
  - 64-bit reads are not atomic; software uses hi-lo-hi.
- Unmapped or out-of-range address (hart index >= NUM_HARTS): read returns 0, write is ignored, ack still asserted.
- Interrupt generation:
  - timer_interrupt[h] <= (mtime >= mtimecmp[h]), unsigned 64-bit compare, registered, so 1 cycle of latency after the condition becomes true.
  - sw_interrupt[h] <= msip[h], registered.
  - Both are levels: they clear only when software raises mtimecmp or clears msip, with the same 1-cycle latency.
- Partial mtimecmp update: writing the low word while the high word is below mtime may raise a spurious interrupt. This is permitted; software writes high = all-ones first.
- No state machine beyond the prescaler and a one-entry response register (ack, rdata).

Decomposition:
- Shared package taiga_types gets:
  - clint_addr_t (16-bit offset type).
  - Constants CLINT_MSIP_BASE, CLINT_MTIMECMP_BASE and CLINT_MTIME_BASE, used as parameter defaults and by the bus decoder in the SoC top.
- Sub-module clint_mtimecmp_reg holds one 64-bit compare register with byte-enable write and a registered compare output. It is instantiated NUM_HARTS times in a generate loop.

Test Plan:
1. Reset, TICK_DIV=1, no accesses -> after 10 cycles read 0xBFF8 = 10 (with the read issued in cycle 10); 0xBFFC = 0; timer_interrupt=0, sw_interrupt=0.
2. Write mtimecmp[1] high=0, low=20 at cycle 5 -> timer_interrupt[1] rises in the cycle after mtime reaches 20; timer_interrupt[0] stays 0. Then write high=1 -> timer_interrupt[1] drops 1 cycle after the ack.
3. Write msip[0]=0xFFFF_FFFF -> sw_interrupt[0]=1 the cycle after ack, and readback = 1. Write 0 -> it clears the same way.
4. Write mtime low=0xFFFF_FFFF, high=0 -> two ticks later high word = 1 and low word = 1, proving the carry.
5. TICK_DIV=4 -> mtime increments once every 4 cycles. A mtime write coinciding with a tick takes the written value with no extra increment.
6. Back-to-back reads in consecutive cycles of unmapped 0x2000, then msip[7] with NUM_HARTS=2 -> ack every cycle, rdata=0, no state change.
